// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and the pipeline sequencer state encoding.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      DDONE  = 2'd2,
      HALTED = 2'd3
   } pctrl_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: flags when the load in ID/EX writes a register read by IF/ID.
module hazard_cmp
   import cpu_types_pkg::*;
(
   input  logic       ex_load,
   input  logic [4:0] ex_wsel,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       lu_stall
);

   regbits_t w_dst;
   logic     w_rs_hit;
   logic     w_rt_hit;

   assign w_dst    = ex_wsel;
   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign w_rs_hit = (w_dst == id_rs);
   assign w_rt_hit = id_uses_rt && (w_dst == id_rt);
   assign lu_stall = ex_load && (w_dst != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: latch enables/flushes, data-memory freeze, load-use, redirect, HALT.
// Define PIPELINE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             m_dmem_req,
   input  logic             m_halt,
   input  logic             ex_load,
   input  logic [4:0]       ex_wsel,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_redirect,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exm_en,
   output logic             mwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exm_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   pctrl_state_t r_state;
   pctrl_state_t w_next;
   logic         r_halt;
   logic         w_lu_stall;
   logic         w_advance;

   hazard_cmp u_hazard_cmp (
      .ex_load    (ex_load),
      .ex_wsel    (ex_wsel),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .lu_stall   (w_lu_stall)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= RUN;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_halt  <= (w_next == HALTED);
      end
   end

   always_comb begin
      w_next     = r_state;
      w_advance  = 1'b0;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exm_en     = 1'b0;
      mwb_en     = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      exm_flush  = 1'b0;

      case (r_state)
         RUN: begin
            // HALT in M retires into WB alone and outranks memory and redirect.
            if (m_halt) begin
               mwb_en = 1'b1;
               w_next = HALTED;
            end else if (m_dmem_req) begin
               w_next = dhit ? DDONE : DWAIT;
            end else begin
               w_advance = ihit;
            end
         end
         DWAIT: begin
            if (dhit) w_next = DDONE;
         end
         DDONE: begin
            if (ihit) begin
               w_advance = 1'b1;
               w_next    = RUN;
            end
         end
         HALTED: w_next = HALTED;
         default: w_next = RUN;
      endcase

      if (w_advance) begin
         pc_en   = 1'b1;
         ifid_en = 1'b1;
         idex_en = 1'b1;
         exm_en  = 1'b1;
         mwb_en  = 1'b1;
         // Redirect squashes the younger instructions, which makes any load-use moot.
         if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (w_lu_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end

      if (!nRST) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_en    = 1'b0;
         exm_en     = 1'b0;
         mwb_en     = 1'b0;
         ifid_flush = 1'b0;
         idex_flush = 1'b0;
         exm_flush  = 1'b0;
      end
   end

   assign halt = r_halt;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] w_one;

   assign w_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // Both counters saturate rather than wrap.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if ((r_state != HALTED) && !pc_en && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + w_one;
         if ((ifid_flush || idex_flush || exm_flush) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + w_one;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic against a flag-based reference model.
module tb_pipeline_ctrl;

   localparam int CNT_W = 32;

   logic             CLK;
   logic             nRST;
   logic             ihit;
   logic             dhit;
   logic             m_dmem_req;
   logic             m_halt;
   logic             ex_load;
   logic [4:0]       ex_wsel;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_redirect;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exm_en;
   logic             mwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exm_flush;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .dhit        (dhit),
      .m_dmem_req  (m_dmem_req),
      .m_halt      (m_halt),
      .ex_load     (ex_load),
      .ex_wsel     (ex_wsel),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_redirect (ex_redirect),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .idex_en     (idex_en),
      .exm_en      (exm_en),
      .mwb_en      (mwb_en),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exm_flush   (exm_flush),
      .halt        (halt),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   // Clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: the pipeline is frozen for memory while a request is outstanding,
   // waits for a fetch once data has returned, or is stopped for good after HALT.
   logic             mdl_stopped;
   logic             mdl_outstanding;
   logic             mdl_returned;
   logic [CNT_W-1:0] mdl_stall;
   logic [CNT_W-1:0] mdl_flush;
   logic [7:0]       exp_q[$];

   task automatic model_reset();
      mdl_stopped     = 1'b0;
      mdl_outstanding = 1'b0;
      mdl_returned    = 1'b0;
      mdl_stall       = '0;
      mdl_flush       = '0;
   endtask

   // Bit order: pc, ifid, idex, exm, mwb enables, then ifid, idex, exm flushes.
   function automatic logic [7:0] predict();
      logic       go;
      logic       dep;
      logic [7:0] v;
      go  = 1'b0;
      v   = 8'b0000_0000;
      dep = 1'b0;
      if (ex_load && ex_wsel != 5'd0) begin
         if (ex_wsel == id_rs) dep = 1'b1;
         if (id_uses_rt && ex_wsel == id_rt) dep = 1'b1;
      end
      if (!nRST || mdl_stopped || mdl_outstanding) go = 1'b0;
      else if (mdl_returned) go = ihit;
      else if (m_halt) v = 8'b0000_1000;
      else if (m_dmem_req) go = 1'b0;
      else go = ihit;
      if (go) begin
         if (ex_redirect) v = 8'b1111_1110;
         else if (dep) v = 8'b0011_1010;
         else v = 8'b1111_1000;
      end
      return v;
   endfunction

   task automatic model_edge(input logic [7:0] e);
      if (!nRST) return;
      if (!mdl_stopped && !e[7] && mdl_stall != '1) mdl_stall = mdl_stall + 1;
      if ((|e[2:0]) && mdl_flush != '1) mdl_flush = mdl_flush + 1;
      if (mdl_stopped) begin
         mdl_stopped = 1'b1;
      end else if (mdl_outstanding) begin
         if (dhit) begin
            mdl_outstanding = 1'b0;
            mdl_returned    = 1'b1;
         end
      end else if (mdl_returned) begin
         if (ihit) mdl_returned = 1'b0;
      end else if (m_halt) begin
         mdl_stopped = 1'b1;
      end else if (m_dmem_req) begin
         if (dhit) mdl_returned = 1'b1;
         else mdl_outstanding = 1'b1;
      end
   endtask

   // Scoreboard
   task automatic check(input string tag, output logic [7:0] e);
      logic [7:0]       o;
      logic [CNT_W-1:0] es;
      logic [CNT_W-1:0] ef;
      exp_q.push_back(predict());
      e = exp_q.pop_front();
      o = {pc_en, ifid_en, idex_en, exm_en, mwb_en, ifid_flush, idex_flush, exm_flush};
`ifdef PIPELINE_CTRL_PERF_EN
      es = mdl_stall;
      ef = mdl_flush;
`else
      es = '0;
      ef = '0;
`endif
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s ctl: observed %b expected %b", tag, o, e);
      end
      vectors++;
      assert (halt === mdl_stopped) else begin
         miscompares++;
         $error("FAIL %s halt: observed %b expected %b", tag, halt, mdl_stopped);
      end
      vectors++;
      assert (stall_cnt === es) else begin
         miscompares++;
         $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt, es);
      end
      vectors++;
      assert (flush_cnt === ef) else begin
         miscompares++;
         $error("FAIL %s flush_cnt: observed %0d expected %0d", tag, flush_cnt, ef);
      end
   endtask

   // Drivers
   task automatic drive(input logic ih, input logic dh, input logic mreq, input logic mh,
                        input logic exl, input logic [4:0] ws, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic redir);
      ihit        = ih;
      dhit        = dh;
      m_dmem_req  = mreq;
      m_halt      = mh;
      ex_load     = exl;
      ex_wsel     = ws;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rt  = urt;
      ex_redirect = redir;
   endtask

   task automatic cycle(input string tag);
      logic [7:0] e;
      #2;
      check(tag, e);
      @(posedge CLK);
      model_edge(e);
      #1;
   endtask

   task automatic do_reset(input int n);
      nRST = 1'b0;
      model_reset();
      repeat (n) cycle("reset");
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b0;
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      do_reset(3);

      drive(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3, 1, 0);
      cycle("first_ihit");

      // Data access: four cycles without dhit, then dhit, then two fetch misses.
      repeat (4) begin
         drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         cycle("dwait");
      end
      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("dhit");
      repeat (2) begin
         drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         cycle("ddone_wait");
      end
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("ddone_adv");

      drive(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd9, 0, 0);
      cycle("load_use_rs");
      drive(1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
      cycle("load_use_rt");
      drive(1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0);
      cycle("rt_unused");
      drive(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
      cycle("wsel_zero");
      drive(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1);
      cycle("redirect_lu");
      drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("ihit_dhit_same");
      drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("ddone_hold");
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
      cycle("ddone_redirect");

      // Reset while data has returned but the fetch has not.
      drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("to_ddone");
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      do_reset(1);
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("post_rst_idle");
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      cycle("post_rst_adv");

      for (int i = 0; i < 400; i++) begin
         if (mdl_stopped && $urandom_range(0, 5) == 0) do_reset(1);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
         cycle("random");
      end

      // HALT outranks a memory request and a redirect, then freezes until reset.
      do_reset(1);
      drive(1, 1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 1);
      cycle("halt_entry");
      repeat (10) begin
         drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         cycle("halted");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
